// File: rtl/axis_pkg.sv
// axis_pkg: shared definitions for the AXI-Stream master/slave pair.
//   AXIS_DATA_W / AXIS_USER_W / AXIS_FIFO_DEPTH : default widths and buffer depth
//   axis_beat_t : one stream beat at the default widths (data, tstrb, tkeep, user, tlast)
//   axis_beat_w : packed beat width for arbitrary data/user widths
package axis_pkg;

  localparam int AXIS_DATA_W     = 32;
  localparam int AXIS_USER_W     = 2;
  localparam int AXIS_FIFO_DEPTH = 4;
  localparam int AXIS_STRB_W     = AXIS_DATA_W / 8;

  // Field order matters: modules with overridden widths declare a local struct
  // with the same ordering so packed layouts stay interchangeable.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic [AXIS_USER_W-1:0] user;
    logic                   tlast;
  } axis_beat_t;

  function automatic int axis_beat_w(input int dw, input int uw);
    return dw + 2 * (dw / 8) + uw + 1;
  endfunction

endpackage

// File: rtl/axis_m_fifo.sv
// axis_m_fifo: beat buffer for axis_master.
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : write request and beat; honoured only when wr_ready=1
//   pop        : read request; honoured only when rd_valid=1
//   rdata      : head entry (zero while empty)
//   wr_ready   : registered "not full" flag
//   rd_valid   : buffer holds at least one beat
//   level      : beats currently buffered
module axis_m_fifo
  import axis_pkg::*;
#(
  parameter  int WIDTH = axis_beat_w(AXIS_DATA_W, AXIS_USER_W),
  parameter  int DEPTH = AXIS_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             do_push, do_pop;

  assign rd_valid = (level != '0);
  assign do_push  = push && wr_ready;
  assign do_pop   = pop && rd_valid;
  // Zero payload while empty keeps outputs clean during and right after reset.
  assign rdata    = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // wr_ready is computed from the next level so it is a plain flop: no path
  // from pop/push to the write side, and it rises the cycle after a pop from full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_nxt;
      wr_ready <= (level_nxt < LW'(DEPTH));
    end
  end

  // Storage needs no reset: rdata is masked until a beat is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axis_master.sv
// axis_master: buffers backend beats and presents them as an AXI-Stream master.
//   axi_aclk, axi_areset : clock, synchronous active-high reset
//   bk_*                 : backend beat input with bk_valid/bk_ready handshake
//   axis_t*              : AXI-Stream master outputs, axis_tready from slave
//   fifo_level           : beats buffered
//   pkt_cnt              : packets (tlast beats) sent, wraps at 16 bits
module axis_master
  import axis_pkg::*;
#(
  parameter  int DATA_WIDTH = AXIS_DATA_W,
  parameter  int USER_WIDTH = AXIS_USER_W,
  parameter  int FIFO_DEPTH = AXIS_FIFO_DEPTH,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  bk_valid,
  input  logic [DATA_WIDTH-1:0] bk_data,
  input  logic [STRB_W-1:0]     bk_tstrb,
  input  logic [STRB_W-1:0]     bk_tkeep,
  input  logic [USER_WIDTH-1:0] bk_user,
  input  logic                  bk_tlast,
  output logic                  bk_ready,
  output logic                  axis_tvalid,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic [STRB_W-1:0]     axis_tstrb,
  output logic [STRB_W-1:0]     axis_tkeep,
  output logic [USER_WIDTH-1:0] axis_tuser,
  output logic                  axis_tlast,
  input  logic                  axis_tready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [15:0]           pkt_cnt
);

  // Same field order as axis_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     tstrb;
    logic [STRB_W-1:0]     tkeep;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
  } beat_t;

  localparam int BEAT_W = axis_beat_w(DATA_WIDTH, USER_WIDTH);

  beat_t in_beat, head;

  assign in_beat = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast};

  axis_m_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .push     (bk_valid),
    .wdata    (in_beat),
    .pop      (axis_tready),
    .rdata    (head),
    .wr_ready (bk_ready),
    .rd_valid (axis_tvalid),
    .level    (fifo_level)
  );

  assign axis_tdata = head.data;
  assign axis_tstrb = head.tstrb;
  assign axis_tkeep = head.tkeep;
  assign axis_tuser = head.user;
  assign axis_tlast = head.tlast;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset)
      pkt_cnt <= '0;
    else if (axis_tvalid && axis_tready && axis_tlast)
      pkt_cnt <= pkt_cnt + 16'd1;
  end

endmodule

// File: tb/tb_axis_master.sv
module tb_axis_master;
  import axis_pkg::*;

  localparam int DW = 32, UW = 2, D = 4, SW = DW / 8, LW = $clog2(D) + 1;
  localparam int BW = $bits(axis_beat_t);

  logic          axi_aclk = 1'b0, axi_areset = 1'b1;
  logic          bk_valid = 1'b0, bk_tlast = 1'b0, axis_tready = 1'b0;
  logic [DW-1:0] bk_data = '0;
  logic [SW-1:0] bk_tstrb = '0, bk_tkeep = '0;
  logic [UW-1:0] bk_user = '0;
  logic          bk_ready, axis_tvalid, axis_tlast;
  logic [DW-1:0] axis_tdata;
  logic [SW-1:0] axis_tstrb, axis_tkeep;
  logic [UW-1:0] axis_tuser;
  logic [LW-1:0] fifo_level;
  logic [15:0]   pkt_cnt;

  int checks = 0, errors = 0;

  axis_master #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(D)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .bk_valid(bk_valid), .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep),
    .bk_user(bk_user), .bk_tlast(bk_tlast), .bk_ready(bk_ready),
    .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tstrb(axis_tstrb),
    .axis_tkeep(axis_tkeep), .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
    .axis_tready(axis_tready), .fifo_level(fifo_level), .pkt_cnt(pkt_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model: a queue of beats ----------------
  axis_beat_t  q[$];
  int unsigned pkts = 0;
  bit          in_rst = 1'b1, edge_rst = 1'b1, chk_en = 1'b0;
  bit          m_push, m_pop;
  axis_beat_t  m_beat;

  always @(posedge axi_aclk) begin
    edge_rst = axi_areset;
    if (axi_areset) begin
      q.delete();
      pkts   = 0;
      in_rst = 1'b1;
    end else begin
      m_push = bk_valid && !in_rst && (q.size() < D);
      m_pop  = axis_tready && (q.size() != 0);
      if (m_pop) begin
        if (q[0].tlast) pkts = (pkts + 1) % 65536;
        q.delete(0);
      end
      if (m_push) begin
        m_beat = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast};
        q.push_back(m_beat);
      end
      in_rst = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0]   pay, ep, prev_pay;
  logic [BW-1:0] hb;
  bit            prev_hold = 1'b0;

  always @(negedge axi_aclk) begin
    if (chk_en) begin
      pay = 64'({axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast});
      ep  = '0;
      if (q.size() != 0) begin
        hb = q[0];
        ep = 64'(hb);
      end
      chk("tvalid", 64'(axis_tvalid), 64'(q.size() != 0));
      chk("payload", pay, ep);
      chk("fifo_level", 64'(fifo_level), 64'(q.size()));
      chk("bk_ready", 64'(bk_ready), 64'(!in_rst && q.size() < D));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(pkts));
      if (prev_hold && !edge_rst) begin
        chk("hold_tvalid", 64'(axis_tvalid), 64'(1));
        chk("hold_payload", pay, prev_pay);
      end
      prev_hold = axis_tvalid && !axis_tready;
      prev_pay  = pay;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic do_reset();
    axi_areset = 1'b1; bk_valid = 1'b0; bk_tlast = 1'b0; axis_tready = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    int n = 0;
    bk_valid = 1'b1; bk_data = d; bk_tstrb = '1; bk_tkeep = '1;
    bk_user = d[UW-1:0]; bk_tlast = last;
    while (!bk_ready && n < 50) begin tick(); n++; end
    if (!bk_ready) timeout("push_wait");
    tick();
    bk_valid = 1'b0; bk_tlast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bk_valid = 1'b0; axis_tready = 1'b1;
    while (axis_tvalid && n < 50) begin tick(); n++; end
    if (axis_tvalid) timeout("drain_wait");
    tick();
  endtask

  int idx, n, sent;
  bit acc;

  initial begin
    // reset state
    do_reset();
    @(negedge axi_aclk);
    chk("rst_tvalid", 64'(axis_tvalid), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_bk_ready", 64'(bk_ready), 64'(0));
    chk("rst_tdata", 64'(axis_tdata), 64'(0));
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    tick();
    axi_areset = 1'b0;
    axis_tready = 1'b1;
    tick();
    @(negedge axi_aclk);
    chk("bk_ready_after_rst", 64'(bk_ready), 64'(1));
    tick();

    // three beats, streaming through
    push(32'h11, 1'b0);
    @(negedge axi_aclk);
    chk("lat_tvalid_11", 64'(axis_tvalid), 64'(1));
    chk("lat_tdata_11", 64'(axis_tdata), 64'h11);
    tick();
    push(32'h22, 1'b0);
    @(negedge axi_aclk);
    chk("lat_tdata_22", 64'(axis_tdata), 64'h22);
    tick();
    push(32'h33, 1'b1);
    @(negedge axi_aclk);
    chk("lat_tdata_33", 64'(axis_tdata), 64'h33);
    chk("lat_tlast_33", 64'(axis_tlast), 64'(1));
    tick();
    @(negedge axi_aclk);
    chk("pkt_cnt_one", 64'(pkt_cnt), 64'(1));
    chk("idle_tvalid", 64'(axis_tvalid), 64'(0));
    tick();

    // fill while stalled
    do_reset();
    axi_areset = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
    @(negedge axi_aclk);
    chk("full_bk_ready", 64'(bk_ready), 64'(0));
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_head", 64'(axis_tdata), 64'h1);
    tick();
    bk_valid = 1'b1; bk_data = 32'h5; bk_tlast = 1'b0;
    tick(); tick();
    @(negedge axi_aclk);
    chk("fifth_rejected_level", 64'(fifo_level), 64'(4));
    chk("stall_head", 64'(axis_tdata), 64'h1);
    tick();

    // one pop at full with bk_valid held: no push that cycle
    axis_tready = 1'b1;
    tick();
    axis_tready = 1'b0; bk_valid = 1'b0;
    @(negedge axi_aclk);
    chk("pop_at_full_level", 64'(fifo_level), 64'(3));
    chk("pop_at_full_ready", 64'(bk_ready), 64'(1));
    chk("pop_at_full_head", 64'(axis_tdata), 64'h2);
    tick();
    drain();

    // random handshakes over 1000 beats
    do_reset();
    axi_areset = 1'b0;
    idx = 1; n = 0; bk_valid = 1'b0;
    while (idx <= 1000 && n < 20000) begin
      if (!bk_valid) begin
        bk_valid = 1'($urandom_range(0, 1));
        if (bk_valid) begin
          bk_data  = $urandom();
          bk_tstrb = 4'($urandom());
          bk_tkeep = 4'($urandom());
          bk_user  = 2'($urandom());
          bk_tlast = (idx % 7 == 0);
        end
      end
      axis_tready = 1'($urandom_range(0, 1));
      acc = bk_valid && bk_ready;
      tick(); n++;
      if (acc) begin idx++; bk_valid = 1'b0; end
    end
    if (idx <= 1000) timeout("random_beats");
    drain();
    @(negedge axi_aclk);
    chk("random_pkt_cnt", 64'(pkt_cnt), 64'd142);
    tick();

    // reset with beats buffered and a stalled slave
    axis_tready = 1'b0;
    push(32'hA1, 1'b0);
    push(32'hA2, 1'b1);
    axi_areset = 1'b1;
    tick();
    @(negedge axi_aclk);
    chk("midrst_tvalid", 64'(axis_tvalid), 64'(0));
    chk("midrst_level", 64'(fifo_level), 64'(0));
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    tick();
    axi_areset = 1'b0; axis_tready = 1'b1;
    repeat (5) tick();
    @(negedge axi_aclk);
    chk("no_stale_tvalid", 64'(axis_tvalid), 64'(0));
    chk("no_stale_pkt_cnt", 64'(pkt_cnt), 64'(0));
    tick();

    // pkt_cnt wrap
    sent = 0; n = 0;
    axis_tready = 1'b1; bk_valid = 1'b1; bk_tlast = 1'b1;
    while (sent < 65535 && n < 70000) begin
      bk_data = 32'(sent);
      if (bk_ready) sent++;
      tick(); n++;
    end
    bk_valid = 1'b0; bk_tlast = 1'b0;
    if (sent < 65535) timeout("wrap_preload");
    drain();
    @(negedge axi_aclk);
    chk("pkt_cnt_ffff", 64'(pkt_cnt), 64'hFFFF);
    tick();
    push(32'hBEEF, 1'b1);
    drain();
    @(negedge axi_aclk);
    chk("pkt_cnt_wrap", 64'(pkt_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
